// File: rtl/div_16b_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and default width.
package div_16b_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_16b_sub_nb.sv
// Combinational W-bit subtractor built as a + ~b + 1; borrow is the inverted carry out.
module sub_nb #(
   parameter int W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic carry;

   assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
   assign borrow        = ~carry;

endmodule

// File: rtl/div_16b.sv
// Iterative unsigned restoring divider, one radix-2 subtract/shift step per clock.
// Results are held in output registers that only change when an operation completes.
module div_16b
   import div_16b_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH:0]   r_reg;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH:0]   r_next;

   // Shift the next dividend bit into the partial remainder, then try subtracting D.
   assign trial  = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
   assign q_next = {q_reg[WIDTH-2:0], ~borrow};
   assign r_next = borrow ? trial : diff;

   sub_nb #(
      .W(WIDTH + 1)
   ) u_sub (
      .a      (trial),
      .b      ({1'b0, d_reg}),
      .diff   (diff),
      .borrow (borrow)
   );

   // A start seen in DONE is treated exactly like one in IDLE so operations can run back to back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         d_reg       <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  d_reg       <= divisor;
                  q_reg       <= dividend;
                  r_reg       <= '0;
                  cnt         <= '0;
                  div_by_zero <= (divisor == '0);
                  if (divisor == '0) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               q_reg <= q_next;
               r_reg <= r_next;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_next;
                  remainder <= r_next[WIDTH-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
